// File: rtl/pipe_pkg.sv
// Shared constants and level encoding for the pipeline stage register.
// Default payload/control widths and a helper that turns slot valids into an occupancy level.
package pipe_pkg;

  localparam int PIPE_DATA_W_DEF = 143;
  localparam int PIPE_CTRL_W_DEF = 3;

  typedef enum logic [1:0] {
    LVL_EMPTY = 2'd0,
    LVL_ONE   = 2'd1,
    LVL_TWO   = 2'd2
  } level_e;

  function automatic level_e levelOf(input logic mainValid, input logic skidValid);
    level_e lvl;
    unique case ({mainValid, skidValid})
      2'b11:        lvl = LVL_TWO;
      2'b10, 2'b01: lvl = LVL_ONE;
      default:      lvl = LVL_EMPTY;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of the stage: valid bit, payload and side-effect controls.
// Flush kills valid and ctrl but leaves the payload alone; load wins over clear.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W_DEF,
  parameter int CTRL_W = PIPE_CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Stored ctrl is zeroed whenever the slot goes invalid, so it can drive outputs directly.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with synchronous flush of side-effect controls.
// Define PIPE_SKID_EN for a main+skid pair with registered in_ready; otherwise a single entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W_DEF,
  parameter int CTRL_W = PIPE_CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        level
);

  logic              mainValid;
  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] mainCtrl;
  logic              acceptIn;
  logic              deliverOut;

  assign acceptIn   = in_valid && in_ready;
  assign deliverOut = mainValid && out_ready;

  assign out_valid = mainValid;
  assign out_data  = mainData;
  assign out_ctrl  = mainCtrl;

`ifdef PIPE_SKID_EN
  logic              skidValid;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;
  logic              mainLoad, mainClear, skidLoad, skidClear;
  logic [DATA_W-1:0] mainLoadData;
  logic [CTRL_W-1:0] mainLoadCtrl;

  assign in_ready = !skidValid;

  // The skid slot is only ever filled while main is held, so it always refills main first.
  always_comb begin
    mainLoad     = 1'b0;
    mainClear    = 1'b0;
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    mainLoadData = in_data;
    mainLoadCtrl = in_ctrl;
    if (skidValid) begin
      mainLoadData = skidData;
      mainLoadCtrl = skidCtrl;
    end
    if (!mainValid) begin
      mainLoad = acceptIn;
    end else if (deliverOut) begin
      mainLoad  = skidValid || acceptIn;
      mainClear = !skidValid && !acceptIn;
      skidClear = skidValid;
    end else begin
      skidLoad = acceptIn;
    end
  end

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .load_i  (mainLoad),
    .clear_i (mainClear),
    .data_i  (mainLoadData),
    .ctrl_i  (mainLoadCtrl),
    .valid_o (mainValid),
    .data_o  (mainData),
    .ctrl_o  (mainCtrl)
  );

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .load_i  (skidLoad),
    .clear_i (skidClear),
    .data_i  (in_data),
    .ctrl_i  (in_ctrl),
    .valid_o (skidValid),
    .data_o  (skidData),
    .ctrl_o  (skidCtrl)
  );

  assign level = levelOf(mainValid, skidValid);
`else
  assign in_ready = !mainValid || out_ready;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .load_i  (acceptIn),
    .clear_i (deliverOut),
    .data_i  (in_data),
    .ctrl_i  (in_ctrl),
    .valid_o (mainValid),
    .data_o  (mainData),
    .ctrl_o  (mainCtrl)
  );

  assign level = levelOf(mainValid, 1'b0);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vectors plus a queue-based reference model.
// Works in both buffering modes (PIPE_SKID_EN defined or not).
module tb_pipe_stage_reg;

  localparam int DW = 143;
  localparam int CW = 3;
`ifdef PIPE_SKID_EN
  localparam int MAXL = 2;
`else
  localparam int MAXL = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    level;

  int nVectors = 0;
  int nMiscompares = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t mq[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .level     (level)
  );

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                               input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic modelReady();
`ifdef PIPE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || out_ready;
`endif
  endfunction

  // Reference model: an ordered FIFO of held entries with capacity set by the mode.
  always @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      mq.delete();
    end else begin
      logic fireIn, fireOut;
      ent_t e;
      fireIn  = in_valid && modelReady();
      fireOut = (mq.size() > 0) && out_ready;
      e.d = in_data;
      e.c = in_ctrl;
      if (fireOut) mq.delete(0);
      if (fireIn) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    logic          expValid;
    logic [CW-1:0] expCtrl;
    expValid = (mq.size() > 0);
    expCtrl  = expValid ? mq[0].c : '0;
    checkOutput("model out_valid", 160'(out_valid), 160'(expValid));
    checkOutput("model out_ctrl", 160'(out_ctrl), 160'(expCtrl));
    checkOutput("model level", 160'(level), 160'(mq.size()));
    checkOutput("model in_ready", 160'(in_ready), 160'(modelReady()));
    if (!reset) checkOutput("model out_data reset", 160'(out_data), 160'(0));
    else if (expValid) checkOutput("model out_data", 160'(out_data), 160'(mq[0].d));
  end

  initial begin
    logic [159:0] rd;
    logic         ordy;

    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'('h5A);
    in_ctrl   = 3'b101;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst out_valid", 160'(out_valid), 160'(0));
    checkOutput("rst out_ctrl", 160'(out_ctrl), 160'(0));
    checkOutput("rst out_data", 160'(out_data), 160'(0));
    checkOutput("rst level", 160'(level), 160'(0));
    checkOutput("rst in_ready", 160'(in_ready), 160'(1));

    reset = 1'b1;
    applyStimulus(1'b1, DW'('h5A), 3'b101, 1'b0, 1'b0);
    checkOutput("first out_valid", 160'(out_valid), 160'(1));
    checkOutput("first out_data", 160'(out_data), 160'('h5A));
    checkOutput("first out_ctrl", 160'(out_ctrl), 160'(3'b101));
    checkOutput("first level", 160'(level), 160'(1));
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("drain out_valid", 160'(out_valid), 160'(0));
    checkOutput("drain out_ctrl", 160'(out_ctrl), 160'(0));

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, DW'('h10 + i), i[2:0], 1'b1, 1'b0);
      checkOutput("stream out_valid", 160'(out_valid), 160'(1));
      checkOutput("stream out_data", 160'(out_data), 160'('h10 + i));
      checkOutput("stream out_ctrl", 160'(out_ctrl), 160'(i[2:0]));
      checkOutput("stream level", 160'(level), 160'(1));
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("stream end out_valid", 160'(out_valid), 160'(0));

    applyStimulus(1'b1, DW'('h20), 3'b001, 1'b1, 1'b0);
    checkOutput("stall pre out_data", 160'(out_data), 160'('h20));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, DW'('h21), 3'b010, 1'b0, 1'b0);
      checkOutput("stall out_valid", 160'(out_valid), 160'(1));
      checkOutput("stall out_data", 160'(out_data), 160'('h20));
      checkOutput("stall out_ctrl", 160'(out_ctrl), 160'(3'b001));
    end
    checkOutput("stall level", 160'(level), 160'(MAXL));
    checkOutput("stall in_ready", 160'(in_ready), 160'(0));
    applyStimulus(1'b1, DW'('h21), 3'b010, 1'b1, 1'b0);
    checkOutput("release out_data", 160'(out_data), 160'('h21));
    checkOutput("release level", 160'(level), 160'(1));
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("release end out_valid", 160'(out_valid), 160'(0));

    applyStimulus(1'b1, DW'('h30), 3'b011, 1'b0, 1'b0);
    applyStimulus(1'b1, DW'('h31), 3'b011, 1'b0, 1'b0);
    checkOutput("prefill level", 160'(level), 160'(MAXL));
    applyStimulus(1'b1, DW'('h32), 3'b111, 1'b0, 1'b1);
    checkOutput("flush out_valid", 160'(out_valid), 160'(0));
    checkOutput("flush out_ctrl", 160'(out_ctrl), 160'(0));
    checkOutput("flush level", 160'(level), 160'(0));
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("post flush out_valid", 160'(out_valid), 160'(0));
    checkOutput("post flush level", 160'(level), 160'(0));

    applyStimulus(1'b1, DW'('h40), 3'b110, 1'b0, 1'b0);
    checkOutput("pre rst out_valid", 160'(out_valid), 160'(1));
    flush = 1'b1;
    reset = 1'b0;
    #1;
    checkOutput("rst+flush out_valid", 160'(out_valid), 160'(0));
    checkOutput("rst+flush out_data", 160'(out_data), 160'(0));
    checkOutput("rst+flush out_ctrl", 160'(out_ctrl), 160'(0));
    checkOutput("rst+flush level", 160'(level), 160'(0));
    checkOutput("rst+flush in_ready", 160'(in_ready), 160'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // Alternating phases of mostly-ready and mostly-stalled downstream exercise fill and drain.
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) reset = 1'b0;
      if (i == 5002) reset = 1'b1;
      rd   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      ordy = ((i % 1000) < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, 3) != 0, rd[DW-1:0], 3'($urandom_range(0, 7)), ordy,
                    $urandom_range(0, 63) == 0);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 143, width of the payload carried unmodified (PC+4, operands, immediate, register indices, datapath selects).
REQ-002 SHALL have parameter CTRL_W, default 3, width of the side-effect controls (MemWrite, MemRead, RegWrite class) zeroed on flush.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous kill of all held and incoming entries.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, DATA_W), in_ctrl (input, CTRL_W): upstream handshake and payload.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, DATA_W), out_ctrl (output, CTRL_W): downstream handshake and payload.
REQ-008 SHALL have port level, output, 2 bits: number of held entries (0..2).

Function
REQ-009 SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-010 SHALL present an accepted entry on out_* the cycle after acceptance (1-cycle latency) when the stage was empty or draining.
REQ-011 SHALL deliver entries in acceptance order, with no loss and no duplication.
REQ-012 SHALL hold out_valid, out_data and out_ctrl stable while out_valid && !out_ready.
REQ-013 SHALL drive out_ctrl to 0 whenever out_valid is 0.
REQ-014 SHALL, on a cycle with flush=1, clear every valid bit and stored ctrl and discard any same-cycle input transfer; level reads 0 the next cycle.
REQ-015 SHALL leave stored data unchanged on flush (data is don't-care while invalid).
REQ-016 SHALL, on simultaneous in and out transfer at level 1, keep level 1 and replace the entry.
REQ-017 SHALL update level as +1 on an input-only transfer, -1 on an output-only transfer, and unchanged otherwise; level never exceeds the configured depth.

Reset
REQ-018 SHALL, while reset=0, force out_valid=0, out_data=0, out_ctrl=0, level=0, all internal valid bits 0, and in_ready=1, independent of clk.
REQ-019 SHALL give reset priority over flush and over any transfer; the first accept is possible on the first clk edge after reset deasserts.
REQ-020 SHALL, when reset is asserted mid-transfer, drop all held entries without emitting partial data.

Configuration
REQ-021 SHALL use macro PIPE_SKID_EN to select the buffering mode.
REQ-022 SHALL, with PIPE_SKID_EN defined, provide a main entry plus a skid entry: in_ready is a registered output equal to !skid_valid, and a transfer accepted while the main entry is stalled lands in the skid entry.
REQ-023 SHALL, with PIPE_SKID_EN defined, move the skid entry into the main entry on the output-transfer cycle; level may reach 2; full throughput is sustained with registered ready.
REQ-024 SHALL, without PIPE_SKID_EN, provide a single entry with combinational in_ready = !out_valid || out_ready; level never exceeds 1.

Structure
REQ-025 SHALL place default DATA_W/CTRL_W constants and the level encoding in shared package pipe_pkg.
REQ-026 SHALL implement each storage slot (valid, data, ctrl, async-reset register with load and clear-on-flush) as sub-module pipe_entry, instantiated once or twice.

Verification
REQ-027 SHALL cover: reset=0 with in_valid=1 and in_data=0x5A -> out_valid=0, out_ctrl=0, level=0, in_ready=1; after release, accept 0x5A -> out_data=0x5A next cycle.
REQ-028 SHALL cover: stream 8 entries with out_ready=1 -> 8 outputs in order, 1-cycle latency, one per cycle.
REQ-029 SHALL cover: out_ready=0 for 3 cycles during a stream -> out_* held stable; with PIPE_SKID_EN, level=2 and in_ready=0; without it, level=1 and in_ready=0.
REQ-030 SHALL cover: flush=1 at level 2 with in_valid=1 and in_ctrl=3'b111 -> next cycle out_valid=0, out_ctrl=0, level=0, and the input is discarded.
REQ-031 SHALL cover: flush=1 and reset=0 in the same cycle -> reset state per REQ-018.
REQ-032 SHALL cover: random in_valid/out_ready over 10k cycles against a scoreboard -> no loss, no duplication, level matches the scoreboard count, in both configurations.
